// File: rtl/game_pkg.sv
// Shared constants and types for the song-upload path: mode values, framing bytes
// and the loader FSM state encoding.
package game_pkg;

    localparam logic [2:0] MODE_EDIT = 3'd4;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CSUM,
        RESP
    } loader_state_t;

endpackage

// File: rtl/uart_song_loader_rx_sync.sv
// Brings the asynchronous rxready level into the clk domain and turns each rising
// edge into a single-cycle byte_valid strobe.
module rx_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic byte_valid
);

    logic [2:0] sync_q;

    // Two flops for metastability, the third remembers the previous level for the edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign byte_valid = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/uart_song_loader.sv
// Receive end of the song-upload link: parses SOF/8 data/checksum frames from the UART,
// commits the two note lanes on a good checksum and answers ACK or NAK.
module uart_song_loader
    import game_pkg::*;
#(
    parameter logic [2:0]  EDIT_MODE      = MODE_EDIT,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000,
    parameter logic [31:0] DEFAULT_NOTES1 = 32'hAAAAAAAA,
    parameter logic [31:0] DEFAULT_NOTES2 = 32'hCCCCCCCC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic [7:0]  rxdata,
    input  logic        rxready,
    output logic        rxclk,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic [31:0] notes1,
    output logic [31:0] notes2,
    output logic        load_done,
    output logic        busy
);

    loader_state_t state, state_n;

    logic        byte_valid;
    logic        in_edit;
    logic        timeout;
    logic [2:0]  cnt;
    logic [7:0]  chk;
    logic [23:0] idle_cnt;
    logic [31:0] shadow1;
    logic [31:0] shadow2;

    rx_strobe_sync u_rx_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (rxready),
        .byte_valid (byte_valid)
    );

    assign in_edit = (mode == EDIT_MODE);
    assign timeout = (idle_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Leaving edit mode aborts a frame, and a byte landing together with the timeout beats it
    always_comb begin
        state_n = state;
        txclk   = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (byte_valid && in_edit && rxdata == SOF_BYTE) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (!in_edit) begin
                    state_n = IDLE;
                end else if (byte_valid) begin
                    if (cnt == 3'd7) begin
                        state_n = CSUM;
                    end
                end else if (timeout) begin
                    state_n = RESP;
                end
            end
            CSUM: begin
                if (!in_edit) begin
                    state_n = IDLE;
                end else if (byte_valid || timeout) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (txready) begin
                    txclk   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: bytes shift in MSB-first, so D0 ends up in bits 31:24 of its lane
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 3'd0;
            chk       <= 8'h00;
            idle_cnt  <= 24'd0;
            shadow1   <= 32'h0;
            shadow2   <= 32'h0;
            notes1    <= DEFAULT_NOTES1;
            notes2    <= DEFAULT_NOTES2;
            txdata    <= 8'h00;
            rxclk     <= 1'b0;
            load_done <= 1'b0;
        end else begin
            rxclk     <= byte_valid;
            load_done <= 1'b0;

            if ((state == DATA || state == CSUM) && !byte_valid) begin
                idle_cnt <= idle_cnt + 24'd1;
            end else begin
                idle_cnt <= 24'd0;
            end

            case (state)
                IDLE: begin
                    if (state_n == DATA) begin
                        cnt     <= 3'd0;
                        chk     <= 8'h00;
                        shadow1 <= 32'h0;
                        shadow2 <= 32'h0;
                    end
                end
                DATA: begin
                    if (in_edit && byte_valid) begin
                        chk <= chk ^ rxdata;
                        cnt <= cnt + 3'd1;
                        if (!cnt[2]) begin
                            shadow1 <= {shadow1[23:0], rxdata};
                        end else begin
                            shadow2 <= {shadow2[23:0], rxdata};
                        end
                    end else if (state_n == RESP) begin
                        txdata <= NAK_BYTE;
                    end
                end
                CSUM: begin
                    if (state_n == RESP) begin
                        if (byte_valid && rxdata == chk) begin
                            txdata    <= ACK_BYTE;
                            notes1    <= shadow1;
                            notes2    <= shadow2;
                            load_done <= 1'b1;
                        end else begin
                            txdata <= NAK_BYTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_song_loader.sv
// Randomised self-checking bench for uart_song_loader against a queue-based frame model.
module tb_uart_song_loader;

    localparam int          TB_TIMEOUT = 300;
    localparam logic [31:0] DEF1       = 32'hAAAAAAAA;
    localparam logic [31:0] DEF2       = 32'hCCCCCCCC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mode = 3'd4;
    logic [7:0]  rxdata = 8'h00;
    logic        rxready = 1'b0;
    logic        rxclk;
    logic        txready = 1'b1;
    logic [7:0]  txdata;
    logic        txclk;
    logic [31:0] notes1;
    logic [31:0] notes2;
    logic        load_done;
    logic        busy;

    uart_song_loader #(
        .EDIT_MODE      (3'd4),
        .TIMEOUT_CYCLES (24'(TB_TIMEOUT)),
        .DEFAULT_NOTES1 (DEF1),
        .DEFAULT_NOTES2 (DEF2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .rxdata    (rxdata),
        .rxready   (rxready),
        .rxclk     (rxclk),
        .txready   (txready),
        .txdata    (txdata),
        .txclk     (txclk),
        .notes1    (notes1),
        .notes2    (notes2),
        .load_done (load_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int load_cnt = 0;
    int tx_cnt = 0;
    int rxclk_cnt = 0;
    int busy_cycles = 0;
    logic [7:0] last_tx = 8'h00;

    // Observed output events, counted mid-cycle
    always @(negedge clk) begin
        if (load_done) load_cnt++;
        if (rxclk) rxclk_cnt++;
        if (busy) busy_cycles++;
        if (txclk) begin
            tx_cnt++;
            last_tx = txdata;
        end
    end

    // Reference model state
    logic        in_frame = 1'b0;
    logic [7:0]  frame_q[$];
    logic [31:0] exp_n1 = DEF1;
    logic [31:0] exp_n2 = DEF2;
    logic [7:0]  exp_last = 8'h00;
    int          exp_loads = 0;
    int          exp_tx = 0;
    int          exp_rx = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [7:0] xorAll(input logic [63:0] d);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 8; i++) x ^= d[8*i +: 8];
        return x;
    endfunction

    task automatic modelByte(input logic [7:0] b);
        logic [7:0] ck;
        exp_rx++;
        if (mode != 3'd4) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (b == 8'hA5) begin
                in_frame = 1'b1;
                frame_q.delete();
            end
        end else if (frame_q.size() < 8) begin
            frame_q.push_back(b);
        end else begin
            ck = 8'h00;
            foreach (frame_q[i]) ck ^= frame_q[i];
            exp_tx++;
            if (ck == b) begin
                exp_n1 = {frame_q[0], frame_q[1], frame_q[2], frame_q[3]};
                exp_n2 = {frame_q[4], frame_q[5], frame_q[6], frame_q[7]};
                exp_loads++;
                exp_last = 8'h06;
            end else begin
                exp_last = 8'h15;
            end
            in_frame = 1'b0;
        end
    endtask

    task automatic modelTimeout();
        if (in_frame) begin
            exp_tx++;
            exp_last = 8'h15;
            in_frame = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxdata  = b;
        rxready = 1'b1;
        tick(6);
        rxready = 1'b0;
        tick(4 + $urandom_range(0, 5));
        modelByte(b);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        in_frame = 1'b0;
        exp_n1   = DEF1;
        exp_n2   = DEF2;
        exp_last = 8'h00;
        tick(1);
    endtask

    task automatic setMode(input logic [2:0] m);
        mode = m;
        if (m != 3'd4) in_frame = 1'b0;
        tick(3);
    endtask

    // Sends SOF, D0 (bits 63:56) .. D7, then the checksum, optionally corrupted
    task automatic sendFrame(input logic [63:0] d, input logic bad_ck);
        applyStimulus(8'hA5);
        for (int i = 7; i >= 0; i--) applyStimulus(d[8*i +: 8]);
        applyStimulus(xorAll(d) ^ {7'd0, bad_ck});
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".notes1"}, notes1, exp_n1);
        checkOutput({tag, ".notes2"}, notes2, exp_n2);
        checkOutput({tag, ".loads"}, load_cnt, exp_loads);
        checkOutput({tag, ".txclks"}, tx_cnt, exp_tx);
        checkOutput({tag, ".txdata"}, txdata, exp_last);
        checkOutput({tag, ".rxclks"}, rxclk_cnt, exp_rx);
        checkOutput({tag, ".busy"}, busy, 0);
    endtask

    logic [63:0] frame;
    int          busy_before;
    int          k;

    initial begin
        frame = 64'h1122334455667788;
        tick(3);
        reset = 1'b0;
        tick(2);
        checkAll("reset");
        checkOutput("reset.load_done", load_done, 0);
        checkOutput("reset.txclk", txclk, 0);

        sendFrame(frame, 1'b0);
        checkAll("good");
        if (last_tx !== 8'h06) checkOutput("good.ack", last_tx, 8'h06);

        applyReset();
        sendFrame(frame, 1'b1);
        checkAll("badck");

        applyStimulus(8'hA5);
        for (int i = 0; i < 3; i++) applyStimulus(8'h10 + 8'(i));
        tick(TB_TIMEOUT + 20);
        modelTimeout();
        checkAll("timeout");
        sendFrame(64'hDEADBEEF01234567, 1'b0);
        checkAll("after_timeout");

        setMode(3'd0);
        busy_before = busy_cycles;
        sendFrame(64'h0102030405060708, 1'b0);
        checkAll("mode0");
        checkOutput("mode0.busy_cycles", busy_cycles, busy_before);
        setMode(3'd4);

        applyStimulus(8'hA5);
        for (int i = 0; i < 6; i++) applyStimulus(8'h31 + 8'(i));
        applyReset();
        checkAll("reset_mid");
        applyStimulus(8'h37);
        applyStimulus(8'h38);
        applyStimulus(8'h00);
        checkAll("reset_tail");

        txready = 1'b0;
        sendFrame(64'h0F1E2D3C4B5A6978, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(10);
            checkOutput("hold.txclk", txclk, 0);
            checkOutput("hold.busy", busy, 1);
        end
        txready = 1'b1;
        #2;
        checkOutput("release.txclk", txclk, 1);
        checkOutput("release.txdata", txdata, 8'h06);
        tick(2);
        checkAll("release");

        for (int it = 0; it < 40; it++) begin
            frame = {$urandom, $urandom};
            k = $urandom_range(1, 7);
            case ($urandom_range(0, 9))
                6: begin
                    setMode(3'($urandom_range(0, 3)));
                    sendFrame(frame, 1'b0);
                    setMode(3'd4);
                end
                7: begin
                    applyStimulus(8'hA5);
                    for (int i = 0; i < k; i++) applyStimulus(frame[8*i +: 8]);
                    tick(TB_TIMEOUT + 20);
                    modelTimeout();
                end
                8: begin
                    applyStimulus(8'hA5);
                    for (int i = 0; i < k; i++) applyStimulus(frame[8*i +: 8]);
                    setMode(3'd5);
                    for (int i = k; i < 8; i++) applyStimulus(frame[8*i +: 8]);
                    setMode(3'd4);
                end
                9: begin
                    for (int i = 0; i < k % 3 + 1; i++) begin
                        applyStimulus((frame[8*i +: 8] == 8'hA5) ? 8'h5A : frame[8*i +: 8]);
                    end
                    sendFrame(frame, 1'b0);
                end
                default: sendFrame(frame, ($urandom_range(0, 3) == 0));
            endcase
            checkAll("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
